// File: rtl/complex_alu_pkg.sv
// complex_alu_pkg: shared widths, opcodes, state/class enums and default latencies for the complex ALU sequencer.
// Define COMPLEX_ALU_EARLY_OUT_EN so DIVU_L/DIVU_H with dividend < divisor (unsigned) complete in one cycle.
package complex_alu_pkg;
  localparam int SIZE_DATA       = 32;
  localparam int SIZE_OPCODE_I   = 6;
  localparam int EXECUTION_FLAGS = 3;
  localparam int DEF_MUL_LAT     = 3;
  localparam int DEF_DIV_LAT     = 16;
  localparam int DEF_TAG_W       = 7;
  localparam logic [EXECUTION_FLAGS-1:0] FLAG_EXC = 3'b010;
  localparam logic [SIZE_OPCODE_I-1:0] OP_MULT_L  = 6'd1;
  localparam logic [SIZE_OPCODE_I-1:0] OP_MULT_H  = 6'd2;
  localparam logic [SIZE_OPCODE_I-1:0] OP_MULTU_L = 6'd3;
  localparam logic [SIZE_OPCODE_I-1:0] OP_MULTU_H = 6'd4;
  localparam logic [SIZE_OPCODE_I-1:0] OP_DIV_L   = 6'd5;
  localparam logic [SIZE_OPCODE_I-1:0] OP_DIV_H   = 6'd6;
  localparam logic [SIZE_OPCODE_I-1:0] OP_DIVU_L  = 6'd7;
  localparam logic [SIZE_OPCODE_I-1:0] OP_DIVU_H  = 6'd8;
  localparam logic [SIZE_OPCODE_I-1:0] OP_SYSCALL = 6'd9;
`ifdef COMPLEX_ALU_EARLY_OUT_EN
  localparam bit EARLY_OUT_EN = 1'b1;
`else
  localparam bit EARLY_OUT_EN = 1'b0;
`endif
  typedef enum logic [1:0] {CX_IDLE, CX_EXEC, CX_DONE} cx_state_t;
  typedef enum logic [1:0] {CLS_MUL, CLS_DIV, CLS_SYS, CLS_OTHER} op_class_t;
endpackage

// File: rtl/complex_alu_if.sv
// complex_alu_if: issue, ALU-hold and writeback signals of the complex ALU sequencer; names are from the controller's view.
interface complex_alu_if
  import complex_alu_pkg::*;
#(
  parameter int TAG_W = DEF_TAG_W
);
  logic                         issue_valid_i, issue_ready_o, flush_i;
  logic [SIZE_OPCODE_I-1:0]     opcode_i, alu_opcode_o;
  logic [SIZE_DATA-1:0]         data1_i, data2_i, alu_data1_o, alu_data2_o;
  logic [TAG_W-1:0]             tag_i, wb_tag_o;
  logic [2*SIZE_DATA-1:0]       alu_result_i, wb_result_o;
  logic [EXECUTION_FLAGS-1:0]   alu_flags_i, wb_flags_o;
  logic                         wb_valid_o, wb_ready_i, busy_o;
  modport master (
    output issue_valid_i, opcode_i, data1_i, data2_i, tag_i, flush_i, alu_result_i, alu_flags_i, wb_ready_i,
    input  issue_ready_o, alu_opcode_o, alu_data1_o, alu_data2_o, wb_valid_o, wb_tag_o, wb_result_o, wb_flags_o, busy_o
  );
  modport slave (
    input  issue_valid_i, opcode_i, data1_i, data2_i, tag_i, flush_i, alu_result_i, alu_flags_i, wb_ready_i,
    output issue_ready_o, alu_opcode_o, alu_data1_o, alu_data2_o, wb_valid_o, wb_tag_o, wb_result_o, wb_flags_o, busy_o
  );
endinterface

// File: rtl/complex_lat_decode.sv
// complex_lat_decode: classifies a complex opcode and derives its hold latency, divide-by-zero and early-out flags.
module complex_lat_decode
  import complex_alu_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT,
  parameter int CNT_W   = 5
) (
  input  logic [SIZE_OPCODE_I-1:0] opcode_i,
  input  logic [SIZE_DATA-1:0]     data1_i,
  input  logic [SIZE_DATA-1:0]     data2_i,
  output op_class_t                cls_o,
  output logic [CNT_W-1:0]         lat_o,
  output logic                     dbz_o,
  output logic                     early_o
);
  always_comb begin
    cls_o   = (opcode_i inside {OP_MULT_L, OP_MULT_H, OP_MULTU_L, OP_MULTU_H}) ? CLS_MUL :
              (opcode_i inside {OP_DIV_L, OP_DIV_H, OP_DIVU_L, OP_DIVU_H})     ? CLS_DIV :
              (opcode_i == OP_SYSCALL)                                        ? CLS_SYS : CLS_OTHER;
    lat_o   = cls_o == CLS_MUL ? CNT_W'(MUL_LAT) : cls_o == CLS_DIV ? CNT_W'(DIV_LAT) : CNT_W'(1);
    dbz_o   = cls_o == CLS_DIV && data2_i == '0;
    early_o = EARLY_OUT_EN && (opcode_i == OP_DIVU_L || opcode_i == OP_DIVU_H) && data1_i < data2_i;
  end
endmodule

// File: rtl/complex_alu_ctrl.sv
// complex_alu_ctrl: holds one complex-ALU operand set for an opcode-dependent number of cycles, then hands the
// captured result to writeback on valid/ready; flush kills the in-flight op.
module complex_alu_ctrl
  import complex_alu_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT,
  parameter int TAG_W   = DEF_TAG_W
) (
  input logic          clk,
  input logic          reset,
  complex_alu_if.slave bus
);
  localparam int MAX_LAT = MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  cx_state_t                  state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d, lat;
  logic [SIZE_OPCODE_I-1:0]   op_q, op_d;
  logic [SIZE_DATA-1:0]       d1_q, d1_d, d2_q, d2_d;
  logic [TAG_W-1:0]           tag_q, tag_d, wb_tag_q, wb_tag_d;
  logic [2*SIZE_DATA-1:0]     wb_res_q, wb_res_d;
  logic [EXECUTION_FLAGS-1:0] wb_flg_q, wb_flg_d;
  logic                       oth_q, oth_d, dbz_q, dbz_d;
  logic                       rdy, fire, done, cap, dbz, early;
  op_class_t                  cls;
  complex_lat_decode #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) u_dec (
    .opcode_i(bus.opcode_i), .data1_i(bus.data1_i), .data2_i(bus.data2_i),
    .cls_o(cls), .lat_o(lat), .dbz_o(dbz), .early_o(early)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q  <= CX_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      d1_q     <= '0;
      d2_q     <= '0;
      tag_q    <= '0;
      oth_q    <= 1'b0;
      dbz_q    <= 1'b0;
      wb_tag_q <= '0;
      wb_res_q <= '0;
      wb_flg_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      d1_q     <= d1_d;
      d2_q     <= d2_d;
      tag_q    <= tag_d;
      oth_q    <= oth_d;
      dbz_q    <= dbz_d;
      wb_tag_q <= wb_tag_d;
      wb_res_q <= wb_res_d;
      wb_flg_q <= wb_flg_d;
    end
  // Flush outranks everything: it blocks the issue and suppresses the capture of a finishing op.
  always_comb begin
    rdy      = !bus.flush_i && (state_q == CX_IDLE || (state_q == CX_DONE && bus.wb_ready_i));
    fire     = bus.issue_valid_i && rdy;
    done     = state_q == CX_EXEC && cnt_q == '0;
    cap      = done && !bus.flush_i;
    state_d  = bus.flush_i ? CX_IDLE : fire ? CX_EXEC : done ? CX_DONE :
               (state_q == CX_DONE && bus.wb_ready_i) ? CX_IDLE : state_q;
    cnt_d    = fire ? ((dbz || early) ? '0 : lat - CNT_W'(1)) :
               (state_q == CX_EXEC && !done) ? cnt_q - CNT_W'(1) : cnt_q;
    op_d     = fire ? bus.opcode_i : op_q;
    d1_d     = fire ? bus.data1_i : d1_q;
    d2_d     = fire ? bus.data2_i : d2_q;
    tag_d    = fire ? bus.tag_i : tag_q;
    oth_d    = fire ? cls == CLS_OTHER : oth_q;
    dbz_d    = fire ? dbz : dbz_q;
    wb_tag_d = cap ? tag_q : wb_tag_q;
    wb_res_d = cap ? ((oth_q || dbz_q) ? '0 : bus.alu_result_i) : wb_res_q;
    wb_flg_d = cap ? (oth_q ? '0 : bus.alu_flags_i | (dbz_q ? FLAG_EXC : '0)) : wb_flg_q;
  end
  always_comb begin
    bus.issue_ready_o = rdy;
    bus.busy_o        = state_q != CX_IDLE;
    bus.wb_valid_o    = state_q == CX_DONE;
    bus.alu_opcode_o  = op_q;
    bus.alu_data1_o   = d1_q;
    bus.alu_data2_o   = d2_q;
    bus.wb_tag_o      = wb_tag_q;
    bus.wb_result_o   = wb_res_q;
    bus.wb_flags_o    = wb_flg_q;
  end
endmodule

// File: tb/tb_complex_alu_ctrl.sv
// tb_complex_alu_ctrl: directed vectors against a cycle-count/scoreboard model of the complex ALU sequencer.
module tb_complex_alu_ctrl;
  import complex_alu_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  complex_alu_if #(.TAG_W(7)) bus ();
  complex_alu_ctrl #(.MUL_LAT(3), .DIV_LAT(16), .TAG_W(7)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [63:0] alu_fn(logic [5:0] op, logic [31:0] a, logic [31:0] b);
    logic signed [63:0] x, y;
    logic signed [31:0] sa, sb;
    x = $signed(a); y = $signed(b); sa = a; sb = b;
    if (op == OP_MULT_L || op == OP_MULT_H) return x * y;
    if (op == OP_MULTU_L || op == OP_MULTU_H) return {32'b0, a} * {32'b0, b};
    if (op == OP_DIV_L || op == OP_DIV_H) return b == 0 ? 64'hDEADBEEF_00000000 : {32'(sa % sb), 32'(sa / sb)};
    if (op == OP_DIVU_L || op == OP_DIVU_H) return b == 0 ? 64'hDEADBEEF_00000000 : {a % b, a / b};
    if (op == OP_SYSCALL) return 64'h5C;
    return 64'h12345678_9ABCDEF0;
  endfunction
  function automatic logic [2:0] aluf_fn(logic [5:0] op, logic [31:0] a, logic [31:0] b);
    logic [63:0] r;
    r = alu_fn(op, a, b);
    return (op >= OP_MULT_L && op <= OP_SYSCALL) ? {r[63], 1'b0, r == 0} : 3'b101;
  endfunction
  function automatic bit is_div(logic [5:0] op);
    return op >= OP_DIV_L && op <= OP_DIVU_H;
  endfunction
  function automatic bit is_known(logic [5:0] op);
    return op >= OP_MULT_L && op <= OP_SYSCALL;
  endfunction
  function automatic int lat_of(logic [5:0] op, logic [31:0] a, logic [31:0] b);
    if (op >= OP_MULT_L && op <= OP_MULTU_H) return 3;
    if (is_div(op) && b == 0) return 1;
    if (EARLY_OUT_EN && (op == OP_DIVU_L || op == OP_DIVU_H) && a < b) return 1;
    if (is_div(op)) return 16;
    return 1;
  endfunction

  // combinational ALU stand-in fed by the controller's held operands
  always_comb begin
    bus.alu_result_i = alu_fn(bus.alu_opcode_o, bus.alu_data1_o, bus.alu_data2_o);
    bus.alu_flags_i  = aluf_fn(bus.alu_opcode_o, bus.alu_data1_o, bus.alu_data2_o);
  end

  // scoreboard: one pending op with the absolute cycle its result must appear
  int cyc, m_due;
  bit m_has;
  logic [63:0] m_res;
  logic [2:0] m_flg;
  logic [6:0] m_tag;
  logic [5:0] m_op;
  logic [31:0] m_d1, m_d2;
  logic m_valid, m_ready;
  assign m_valid = m_has && cyc >= m_due;
  assign m_ready = !bus.flush_i && (!m_has || (m_valid && bus.wb_ready_i));
  always @(posedge clk or negedge reset)
    if (!reset) begin
      cyc <= 0; m_due <= 0; m_has <= 1'b0; m_op <= '0; m_d1 <= '0; m_d2 <= '0;
    end else begin
      cyc <= cyc + 1;
      if (bus.flush_i) m_has <= 1'b0;
      else if (bus.issue_valid_i && m_ready) begin
        m_has <= 1'b1;
        m_due <= cyc + 1 + lat_of(bus.opcode_i, bus.data1_i, bus.data2_i);
        m_op  <= bus.opcode_i; m_d1 <= bus.data1_i; m_d2 <= bus.data2_i; m_tag <= bus.tag_i;
        m_res <= (!is_known(bus.opcode_i) || (is_div(bus.opcode_i) && bus.data2_i == 0)) ? 64'h0 :
                 alu_fn(bus.opcode_i, bus.data1_i, bus.data2_i);
        m_flg <= !is_known(bus.opcode_i) ? 3'b000 :
                 aluf_fn(bus.opcode_i, bus.data1_i, bus.data2_i) | ((is_div(bus.opcode_i) && bus.data2_i == 0) ? 3'b010 : 3'b000);
      end else if (m_valid && bus.wb_ready_i) m_has <= 1'b0;
    end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (reset) begin
      chk("valid", 64'(bus.wb_valid_o), 64'(m_valid));
      chk("busy", 64'(bus.busy_o), 64'(m_has));
      chk("issue_ready", 64'(bus.issue_ready_o), 64'(m_ready));
      chk("alu_opcode", 64'(bus.alu_opcode_o), 64'(m_op));
      chk("alu_data1", 64'(bus.alu_data1_o), 64'(m_d1));
      chk("alu_data2", 64'(bus.alu_data2_o), 64'(m_d2));
      if (m_valid) begin
        chk("wb_tag", 64'(bus.wb_tag_o), 64'(m_tag));
        chk("wb_result", bus.wb_result_o, m_res);
        chk("wb_flags", 64'(bus.wb_flags_o), 64'(m_flg));
      end
    end

  task automatic tick;
    @(posedge clk); #1;
  endtask
  task automatic present(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input logic [6:0] t);
    bus.issue_valid_i = 1'b1; bus.opcode_i = op; bus.data1_i = a; bus.data2_i = b; bus.tag_i = t;
  endtask
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input logic [6:0] t,
                        output int n, output bit rdy_seen);
    present(op, a, b, t);
    n = 0; rdy_seen = 1'b0;
    do begin
      tick(); n++; bus.issue_valid_i = 1'b0; rdy_seen |= bus.issue_ready_o;
    end while (!bus.wb_valid_o && n < 64);
  endtask
  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_valid"}, 64'(bus.wb_valid_o), 0);
    chk({nm, "_busy"}, 64'(bus.busy_o), 0);
    chk({nm, "_ready"}, 64'(bus.issue_ready_o), 1);
    chk({nm, "_alu_op"}, 64'(bus.alu_opcode_o), 0);
    chk({nm, "_alu_d1"}, 64'(bus.alu_data1_o), 0);
    chk({nm, "_wb_res"}, bus.wb_result_o, 0);
    chk({nm, "_wb_tag"}, 64'(bus.wb_tag_o), 0);
    chk({nm, "_wb_flags"}, 64'(bus.wb_flags_o), 0);
  endtask

  initial begin
    int n, cnt;
    bit r;
    logic [63:0] held;
    bus.issue_valid_i = 1'b0; bus.flush_i = 1'b0; bus.wb_ready_i = 1'b1;
    bus.opcode_i = '0; bus.data1_i = '0; bus.data2_i = '0; bus.tag_i = '0;
    tick(); tick();
    chk_reset_outputs("rst");
    reset = 1'b1;
    tick();
    // MULTU_L 7*6 with writeback stalled: 4-cycle latency, ready low throughout
    bus.wb_ready_i = 1'b0;
    run_op(OP_MULTU_L, 7, 6, 7'd1, n, r);
    chk("mul_lat", 64'(n), 4);
    chk("mul_lo", 64'(bus.wb_result_o[31:0]), 42);
    chk("mul_ready_low", 64'(r), 0);
    chk("mul_tag", 64'(bus.wb_tag_o), 1);
    held = bus.wb_result_o;
    for (int i = 0; i < 5; i++) tick();
    chk("hold_valid", 64'(bus.wb_valid_o), 1);
    chk("hold_result", bus.wb_result_o, held);
    chk("hold_ready", 64'(bus.issue_ready_o), 0);
    // consume and re-issue in the same cycle
    bus.wb_ready_i = 1'b1;
    run_op(OP_MULT_L, 32'hFFFFFFFD, 5, 7'd2, n, r);
    chk("b2b_lat", 64'(n), 4);
    chk("b2b_result", bus.wb_result_o, 64'hFFFFFFFF_FFFFFFF1);
    run_op(OP_DIV_L, 32'hFFFFFFEC, 3, 7'd3, n, r);
    chk("div_lat", 64'(n), 17);
    chk("div_lo", 64'(bus.wb_result_o[31:0]), 64'hFFFFFFFA);
    run_op(OP_DIVU_H, 5, 0, 7'd4, n, r);
    chk("dbz_lat", 64'(n), 2);
    chk("dbz_result", bus.wb_result_o, 0);
    chk("dbz_exc", 64'(bus.wb_flags_o[1]), 1);
    run_op(OP_DIVU_L, 3, 10, 7'd5, n, r);
    chk("early_lat", 64'(n), EARLY_OUT_EN ? 2 : 17);
    chk("early_lo", 64'(bus.wb_result_o[31:0]), 0);
    run_op(OP_SYSCALL, 1, 2, 7'd6, n, r);
    chk("sys_lat", 64'(n), 2);
    chk("sys_result", bus.wb_result_o, 64'h5C);
    run_op(6'h3F, 1, 2, 7'd7, n, r);
    chk("other_lat", 64'(n), 2);
    chk("other_result", bus.wb_result_o, 0);
    chk("other_flags", 64'(bus.wb_flags_o), 0);
    tick();
    // flush a divide at cycle 8 while another issue is presented
    present(OP_DIV_L, 100, 7, 7'd8);
    for (int i = 0; i < 8; i++) begin tick(); bus.issue_valid_i = 1'b0; end
    bus.flush_i = 1'b1;
    present(OP_MULTU_L, 2, 2, 7'd9);
    #1;
    chk("flush_ready", 64'(bus.issue_ready_o), 0);
    tick();
    bus.flush_i = 1'b0; bus.issue_valid_i = 1'b0;
    chk("flush_busy", 64'(bus.busy_o), 0);
    chk("flush_valid", 64'(bus.wb_valid_o), 0);
    cnt = 0;
    for (int i = 0; i < 24; i++) begin tick(); cnt += int'(bus.wb_valid_o); end
    chk("flush_no_valid", 64'(cnt), 0);
    // reset in the middle of a divide
    run_op(OP_MULTU_L, 9, 9, 7'd10, n, r);
    chk("pre_rst_result", 64'(bus.wb_result_o[31:0]), 81);
    tick();
    present(OP_DIV_L, 50, 5, 7'd11);
    for (int i = 0; i < 5; i++) begin tick(); bus.issue_valid_i = 1'b0; end
    #2 reset = 1'b0;
    #1 chk_reset_outputs("midrst");
    tick(); tick();
    reset = 1'b1;
    tick();
    run_op(OP_MULTU_L, 7, 6, 7'd12, n, r);
    chk("post_rst_lat", 64'(n), 4);
    chk("post_rst_lo", 64'(bus.wb_result_o[31:0]), 42);
    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
